// File: rtl/sram_array_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_array_ctrl_if
// Brief    : Request/response bus between a requester and sram_array_ctrl.
// Revision : 1.0
// ============================================================================
interface sram_array_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int SEG_W  = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [ADDR_W-1:0]        req_addr;
    logic [DATA_W-1:0]        req_wdata;
    logic [DATA_W/SEG_W-1:0]  req_wmask;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/sram_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_array_ctrl
// Brief    : Word SRAM array with precharge/wordline sequencing and clear sweep.
// Revision : 1.0
// ============================================================================
module sram_array_ctrl #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 12,
    parameter int ADDR_W = 4,
    parameter int SEG_W  = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    sram_array_ctrl_if.slave    bus,
    output logic                init_done,
    output logic                pre_active,
    output logic                wl_active
);
    localparam int                c_NSEG = DATA_W / SEG_W;
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_PRE   = 3'd2,
        S_ACC   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_NSEG-1:0]   r_wmask;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                r_init_done;
    logic                w_in_range;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    // Addresses past DEPTH never alias onto real words.
    assign w_in_range = (32'(r_addr) < DEPTH);

    always_comb begin
        w_next        = r_state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        pre_active    = 1'b0;
        wl_active     = 1'b0;
        case (r_state)
            S_CLEAR: if (r_clr_addr == c_LAST) w_next = S_IDLE;
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) w_next = S_PRE;
            end
            S_PRE: begin
                pre_active = 1'b1;
                w_next     = S_ACC;
            end
            S_ACC: begin
                wl_active = 1'b1;
                w_next    = r_we ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_CLEAR;
            r_clr_addr  <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == c_LAST) r_init_done <= 1'b1;
                end
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_wmask <= bus.req_wmask;
                    end
                end
                S_ACC: begin
                    if (!r_we) begin
                        r_rdata <= w_in_range ? r_mem[r_addr] : '0;
                        r_err   <= !w_in_range;
                    end
                end
                default: ;
            endcase
        end
    end

    // The array itself is not reset; the sweep clears it instead.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_clr_addr] <= '0;
            end else if (r_state == S_ACC && r_we && w_in_range) begin
                for (int i = 0; i < c_NSEG; i++) begin
                    if (r_wmask[i]) r_mem[r_addr][i*SEG_W +: SEG_W] <= r_wdata[i*SEG_W +: SEG_W];
                end
            end
        end
    end

    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign init_done     = r_init_done;
endmodule
`default_nettype wire

// File: tb/tb_sram_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_array_ctrl
// Brief    : Self-checking bench for sram_array_ctrl against a word-array model.
// Revision : 1.0
// ============================================================================
module tb_sram_array_ctrl;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 12;
    localparam int ADDR_W = 4;
    localparam int SEG_W  = 4;
    localparam int NSEG   = DATA_W / SEG_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic init_done, pre_active, wl_active;

    sram_array_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEG_W(SEG_W)) bus ();

    sram_array_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SEG_W(SEG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .init_done  (init_done),
        .pre_active (pre_active),
        .wl_active  (wl_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;
    logic [DATA_W-1:0] model [DEPTH];

    always @(negedge clk) if (pre_active && wl_active) overlap_cnt++;

    function automatic void model_write(input int a, input logic [DATA_W-1:0] d, input logic [NSEG-1:0] m);
        logic [DATA_W-1:0] bm;
        bm = '0;
        for (int i = 0; i < NSEG; i++) if (m[i]) bm = bm | (DATA_W'(16'hF) << (i * SEG_W));
        if (a < DEPTH) model[a] = (model[a] & ~bm) | (d & bm);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endfunction

    task automatic wait_sweep(output int cyc, output bit mism);
        cyc = 0;
        mism = 0;
        while (!bus.req_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (init_done !== bus.req_ready) mism = 1;
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [NSEG-1:0] m,
                            output int lat, output bit to, output logic [5:0] ph);
        int n;
        n = 0;
        to = 0;
        while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) to = 1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmask = m;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_wdata = DATA_W'($urandom);
        bus.req_wmask = NSEG'($urandom);
        lat = 1;
        ph = {4'b0, pre_active, wl_active};
        while (!bus.req_ready && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat <= 3) ph = {ph[3:0], pre_active, wl_active};
        end
        if (lat >= 100) to = 1;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input int delay,
                           output logic [DATA_W-1:0] data, output logic err, output int lat,
                           output bit to, output bit stable_ok, output bit drop_ok, output logic [5:0] ph);
        int n;
        n = 0;
        to = 0;
        while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) to = 1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        bus.rsp_ready = (delay == 0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = ADDR_W'($urandom);
        lat = 1;
        ph = {4'b0, pre_active, wl_active};
        while (!bus.rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat <= 3) ph = {ph[3:0], pre_active, wl_active};
        end
        if (lat >= 100) to = 1;
        data = bus.rsp_rdata;
        err  = bus.rsp_err;
        stable_ok = 1;
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            if (bus.rsp_rdata !== data || bus.rsp_err !== err || bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0)
                stable_ok = 0;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drop_ok = (bus.rsp_valid === 1'b0) && (bus.req_ready === 1'b1);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        bit mism;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 16'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); end
        checks++; if ({init_done, pre_active, wl_active} !== 3'b000)
            begin errors++; $display("FAIL reset_status got %b want 000", {init_done, pre_active, wl_active}); end
        reset = 1'b0;
        wait_sweep(cyc, mism);
        model_clear();
        checks++; if (cyc !== DEPTH) begin errors++; $display("FAIL sweep_cycles got %0d want %0d", cyc, DEPTH); end
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL sweep_init_done got %b want 1", init_done); end
        checks++; if (mism !== 1'b0) begin errors++; $display("FAIL sweep_ready_vs_done got mismatch=%b want 0", mism); end
    endtask

    task automatic test_sweep_read();
        logic [DATA_W-1:0] d;
        logic e;
        int lat;
        bit to, st, dr;
        logic [5:0] ph;
        for (int a = 0; a < DEPTH; a++) begin
            do_read(ADDR_W'(a), 0, d, e, lat, to, st, dr, ph);
            checks++; if (d !== 16'h0 || e !== 1'b0 || to)
                begin errors++; $display("FAIL sweep_read[%0d] got %h err=%b to=%b want 0000 err=0", a, d, e, to); end
        end
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] d;
        logic e;
        int lat;
        bit to, st, dr;
        logic [5:0] ph;
        do_write(4'd5, 16'hBEEF, 4'hF, lat, to, ph);
        model_write(5, 16'hBEEF, 4'hF);
        checks++; if (lat !== 3 || to) begin errors++; $display("FAIL write_latency got %0d want 3", lat); end
        checks++; if (ph !== 6'b10_01_00) begin errors++; $display("FAIL write_phases got %b want 100100", ph); end
        do_read(4'd5, 0, d, e, lat, to, st, dr, ph);
        checks++; if (lat !== 3 || to) begin errors++; $display("FAIL read_latency got %0d want 3", lat); end
        checks++; if (ph !== 6'b10_01_00) begin errors++; $display("FAIL read_phases got %b want 100100", ph); end
        checks++; if (d !== 16'hBEEF || e !== 1'b0) begin errors++; $display("FAIL read_beef got %h err=%b want beef err=0", d, e); end
        checks++; if (dr !== 1'b1) begin errors++; $display("FAIL read_drop got %b want 1", dr); end
    endtask

    task automatic test_masked();
        logic [DATA_W-1:0] d;
        logic e;
        int lat;
        bit to, st, dr;
        logic [5:0] ph;
        do_write(4'd5, 16'h1234, 4'b0101, lat, to, ph);
        model_write(5, 16'h1234, 4'b0101);
        do_read(4'd5, 0, d, e, lat, to, st, dr, ph);
        checks++; if (d !== 16'hB2E4) begin errors++; $display("FAIL masked_write got %h want b2e4", d); end
        checks++; if (d !== model[5]) begin errors++; $display("FAIL masked_model got %h want %h", d, model[5]); end
        do_write(4'd5, 16'hFFFF, 4'b0000, lat, to, ph);
        checks++; if (lat !== 3 || ph !== 6'b10_01_00) begin errors++; $display("FAIL zero_mask_seq got lat=%0d ph=%b want 3 100100", lat, ph); end
        do_read(4'd5, 0, d, e, lat, to, st, dr, ph);
        checks++; if (d !== 16'hB2E4) begin errors++; $display("FAIL zero_mask_write got %h want b2e4", d); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] d;
        logic e;
        int lat;
        bit to, st, dr;
        logic [5:0] ph;
        do_read(4'd5, 5, d, e, lat, to, st, dr, ph);
        checks++; if (d !== 16'hB2E4 || lat !== 3) begin errors++; $display("FAIL bp_data got %h lat=%0d want b2e4 lat=3", d, lat); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL bp_stable got %b want 1", st); end
        checks++; if (dr !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", dr); end
    endtask

    task automatic test_out_of_range();
        logic [DATA_W-1:0] d;
        logic e;
        int lat;
        bit to, st, dr;
        logic [5:0] ph;
        do_read(4'd13, 0, d, e, lat, to, st, dr, ph);
        checks++; if (d !== 16'h0 || e !== 1'b1) begin errors++; $display("FAIL oor_read13 got %h err=%b want 0000 err=1", d, e); end
        do_write(4'd14, 16'hFFFF, 4'hF, lat, to, ph);
        checks++; if (lat !== 3) begin errors++; $display("FAIL oor_write_latency got %0d want 3", lat); end
        for (int a = 0; a < DEPTH; a++) begin
            do_read(ADDR_W'(a), 0, d, e, lat, to, st, dr, ph);
            checks++; if (d !== model[a] || e !== 1'b0)
                begin errors++; $display("FAIL oor_unchanged[%0d] got %h err=%b want %h err=0", a, d, e, model[a]); end
        end
        do_read(4'd15, 0, d, e, lat, to, st, dr, ph);
        checks++; if (d !== 16'h0 || e !== 1'b1) begin errors++; $display("FAIL oor_read15 got %h err=%b want 0000 err=1", d, e); end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] d, wd, exp_d;
        logic [NSEG-1:0] m;
        logic e, exp_e;
        logic [ADDR_W-1:0] a;
        int lat;
        bit to, st, dr;
        logic [5:0] ph;
        for (int n = 0; n < 80; n++) begin
            a  = ADDR_W'($urandom_range(0, 15));
            wd = DATA_W'($urandom);
            m  = NSEG'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, wd, m, lat, to, ph);
                model_write(int'(a), wd, m);
                checks++; if (lat !== 3 || to) begin errors++; $display("FAIL rnd_write[%0d] latency got %0d want 3", n, lat); end
            end else begin
                do_read(a, $urandom_range(0, 3), d, e, lat, to, st, dr, ph);
                exp_d = (int'(a) < DEPTH) ? model[a] : '0;
                exp_e = (int'(a) >= DEPTH);
                checks++; if (d !== exp_d || e !== exp_e || lat !== 3 || !st || !dr)
                    begin errors++; $display("FAIL rnd_read[%0d] a=%0d got %h err=%b lat=%0d st=%b dr=%b want %h err=%b lat=3",
                                             n, a, d, e, lat, st, dr, exp_d, exp_e); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] d;
        logic e;
        int lat, cyc;
        bit to, st, dr, mism;
        logic [5:0] ph;
        do_write(4'd3, 16'h5A5A, 4'hF, lat, to, ph);
        model_write(3, 16'h5A5A, 4'hF);
        do_read(4'd3, 0, d, e, lat, to, st, dr, ph);
        checks++; if (d !== 16'h5A5A) begin errors++; $display("FAIL mid_preload got %h want 5a5a", d); end
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 4'd3;
        bus.req_wdata = 16'hC3C3;
        bus.req_wmask = 4'hF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (wl_active !== 1'b1) begin errors++; $display("FAIL mid_in_acc got %b want 1", wl_active); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, init_done, pre_active, wl_active} !== 6'b0 || bus.rsp_rdata !== 16'h0)
            begin errors++; $display("FAIL mid_reset_outputs got %b rdata=%h want 000000 rdata=0000",
                                     {bus.req_ready, bus.rsp_valid, bus.rsp_err, init_done, pre_active, wl_active}, bus.rsp_rdata); end
        reset = 1'b0;
        wait_sweep(cyc, mism);
        model_clear();
        checks++; if (cyc !== DEPTH || mism) begin errors++; $display("FAIL mid_sweep got %0d want %0d", cyc, DEPTH); end
        do_read(4'd3, 0, d, e, lat, to, st, dr, ph);
        checks++; if (d !== 16'h0 || e !== 1'b0) begin errors++; $display("FAIL mid_addr3 got %h want 0000", d); end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_sweep_read();
        test_write_read();
        test_masked();
        test_backpressure();
        test_out_of_range();
        test_random();
        test_reset_mid();
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL phase_overlap got %0d want 0", overlap_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
